// File: rtl/pipe_em_stage.sv
// EX->MEM stage register with valid/ready, optional skid entry, flush.
// Define PIPE_EM_PERF_EN to add the stall_cnt/bubble_cnt counters.
module pipe_em_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int SKID = 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          e_valid,
  output logic          e_ready,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic          ewmem,
  input  logic [DW-1:0] ealu,
  input  logic [DW-1:0] eb,
  input  logic [RW-1:0] ern,
  input  logic          flush,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          mwreg,
  output logic          mm2reg,
  output logic          mwmem,
  output logic [DW-1:0] malu,
  output logic [DW-1:0] mb,
  output logic [RW-1:0] mrn
`ifdef PIPE_EM_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   bubble_cnt
`endif
);

  localparam int EW = 3 + 2 * DW + RW;

  logic [EW-1:0] in_w;
  logic [EW-1:0] h_q, h_d;
  logic [EW-1:0] s_q, s_d;
  logic          hv_q, hv_d;
  logic          sv_q, sv_d;
  logic          acc, ret;
  logic          h_wreg, h_m2reg, h_wmem;

  assign in_w = {ewreg, em2reg, ewmem, ealu, eb, ern};

  assign e_ready = (SKID != 0) ? !sv_q
                               : (!hv_q | m_ready);
  assign acc = e_valid & e_ready;
  assign ret = hv_q & m_ready;

  always_comb begin
    hv_d = hv_q;
    sv_d = sv_q;
    h_d  = h_q;
    s_d  = s_q;
    if (flush) begin
      hv_d = 1'b0;
      sv_d = 1'b0;
    end else if (SKID != 0) begin
      if (!hv_q) begin
        if (acc) begin
          hv_d = 1'b1;
          h_d  = in_w;
        end
      end else if (ret) begin
        if (sv_q) begin
          h_d  = s_q;
          sv_d = 1'b0;
        end else if (acc) begin
          h_d = in_w;
        end else begin
          hv_d = 1'b0;
        end
      end else if (acc) begin
        s_d  = in_w;
        sv_d = 1'b1;
      end
    end else begin
      if (acc) begin
        hv_d = 1'b1;
        h_d  = in_w;
      end else if (ret) begin
        hv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hv_q <= 1'b0;
      sv_q <= 1'b0;
      h_q  <= '0;
      s_q  <= '0;
    end else begin
      hv_q <= hv_d;
      sv_q <= sv_d;
      h_q  <= h_d;
      s_q  <= s_d;
    end
  end

  assign {h_wreg, h_m2reg, h_wmem, malu, mb, mrn} = h_q;

  // Controls are gated so an empty stage never issues writes.
  assign m_valid = hv_q;
  assign mwreg   = h_wreg  & hv_q;
  assign mm2reg  = h_m2reg & hv_q;
  assign mwmem   = h_wmem  & hv_q;

`ifdef PIPE_EM_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hv_q && !m_ready && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!hv_q && bubble_cnt_q != 32'hFFFF_FFFF)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
